// File: rtl/apb_csr_responder_if.sv
// ---------------------------------------------------------------------------
// apb_csr_responder_if
//
// Purpose: APB bus bundle between the bench-side APB initiator and the
//          apb_csr_responder completer. The bus has no PREADY, so every
//          transfer completes in its ACCESS phase.
//
// Signals:
//   paddr   [7:0]  word-aligned register address (bits [1:0] ignored)
//   psel           transfer select
//   penable        ACCESS-phase qualifier
//   pwrite         1 = write, 0 = read
//   pwdata  [31:0] write data
//   prdata  [31:0] registered read data from the completer
//   pslverr        error flag, present only when APB_PSLVERR_EN is defined
//
// Modports: master (initiator side), slave (completer side).
// Optional feature macro: APB_PSLVERR_EN.
// ---------------------------------------------------------------------------
interface apb_csr_responder_if;
    logic [7:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
`ifdef APB_PSLVERR_EN
    logic        pslverr;

    modport master (output paddr, psel, penable, pwrite, pwdata,
                    input  prdata, pslverr);
    modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                    output prdata, pslverr);
`else
    modport master (output paddr, psel, penable, pwrite, pwdata,
                    input  prdata);
    modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                    output prdata);
`endif
endinterface

// File: rtl/apb_csr_responder.sv
// ---------------------------------------------------------------------------
// apb_csr_responder
//
// Purpose: APB completer for the packet-decoder core. Provides control,
//          status, result, scratch and ID registers, plus an input-word FIFO
//          that streams 32-bit puzzle words to the core.
//
// Ports:
//   clk          single clock, all logic on posedge
//   rst          synchronous active-high reset
//   apb          APB bus (slave modport): paddr/psel/penable/pwrite/pwdata
//                in, prdata (and pslverr when enabled) out
//   core_start   one-cycle start pulse to the core
//   core_busy    core running
//   core_done    one-cycle completion pulse from the core
//   core_result  core result bus, RESULT_W bits
//   word_valid   FIFO non-empty
//   word_data    FIFO head word
//   word_ready   core pops the head when word_valid & word_ready
//
// Register map (byte address): 0x00 CTRL (W), 0x04 STATUS (R),
//   0x08 DATA_IN (W), 0x0C RESULT_LO (R), 0x10 RESULT_HI (R),
//   0x14 SCRATCH (RW), 0x18 ID (R).
//
// Optional feature macro: APB_PSLVERR_EN adds a registered pslverr flag.
// ---------------------------------------------------------------------------
module apb_csr_responder #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] ID_VALUE   = 32'hA0C2_0016,
    parameter int unsigned RESULT_W   = 64
) (
    input  logic                clk,
    input  logic                rst,
    apb_csr_responder_if.slave  apb,
    output logic                core_start,
    input  logic                core_busy,
    input  logic                core_done,
    input  logic [RESULT_W-1:0] core_result,
    output logic                word_valid,
    output logic [31:0]         word_data,
    input  logic                word_ready
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [5:0] IDX_CTRL    = 6'h00;
    localparam logic [5:0] IDX_STATUS  = 6'h01;
    localparam logic [5:0] IDX_DATA_IN = 6'h02;
    localparam logic [5:0] IDX_RES_LO  = 6'h03;
    localparam logic [5:0] IDX_RES_HI  = 6'h04;
    localparam logic [5:0] IDX_SCRATCH = 6'h05;
    localparam logic [5:0] IDX_ID      = 6'h06;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_HOLD} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_prdata;
    logic        r_core_start;
    logic        r_done_sticky;
    logic        r_overflow;
    logic [31:0] r_scratch;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [5:0]  w_idx;
    logic        w_commit;
    logic        w_wr_commit;
    logic        w_rd_commit;
    logic        w_start;
    logic        w_clear;
    logic        w_push;
    logic        w_push_ok;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_count8;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_readable;
    logic        w_writable;

    // The transfer commits only on the edge where SETUP sees the ACCESS
    // phase, so a held psel/penable can never re-commit the same transfer.
    assign w_idx       = apb.paddr[7:2];
    assign w_commit    = (r_state == ST_SETUP) && apb.psel && apb.penable;
    assign w_wr_commit = w_commit && apb.pwrite;
    assign w_rd_commit = w_commit && !apb.pwrite;
    assign w_start     = w_wr_commit && (w_idx == IDX_CTRL) && apb.pwdata[0];
    assign w_clear     = w_wr_commit && (w_idx == IDX_CTRL) && apb.pwdata[1];
    assign w_push      = w_wr_commit && (w_idx == IDX_DATA_IN);
    assign w_push_ok   = w_push && !w_full;
    assign w_pop       = word_valid && word_ready;
    assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_count8    = 8'(r_count);
    assign w_status    = {16'h0000, w_count8, 3'b000, r_overflow, w_empty,
                          w_full, r_done_sticky, core_busy};

    assign core_start  = r_core_start;
    assign word_valid  = !w_empty;
    assign word_data   = r_mem[r_rd_ptr];
    assign apb.prdata  = r_prdata;

    // Transfer FSM state register; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. IDLE only leaves on a genuine SETUP phase, so a bus
    // still showing psel & penable after reset commits nothing. ACCESS and
    // HOLD share transitions so a back-to-back SETUP right after a commit
    // is not missed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if (!apb.psel)        w_next_state = ST_IDLE;
                else if (apb.penable) w_next_state = ST_ACCESS;
            end
            ST_ACCESS, ST_HOLD: begin
                if (!apb.psel)         w_next_state = ST_IDLE;
                else if (!apb.penable) w_next_state = ST_SETUP;
                else                   w_next_state = ST_HOLD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Read mux and access-permission decode for the current address.
    always_comb begin
        w_rdata    = '0;
        w_readable = 1'b0;
        w_writable = 1'b0;
        case (w_idx)
            IDX_CTRL:    w_writable = 1'b1;
            IDX_STATUS:  begin w_readable = 1'b1; w_rdata = w_status; end
            IDX_DATA_IN: w_writable = 1'b1;
            IDX_RES_LO:  begin w_readable = 1'b1; w_rdata = core_result[31:0]; end
            IDX_RES_HI:  begin
                w_readable = 1'b1;
                w_rdata    = 32'(core_result[RESULT_W-1:32]);
            end
            IDX_SCRATCH: begin
                w_readable = 1'b1;
                w_writable = 1'b1;
                w_rdata    = r_scratch;
            end
            IDX_ID:      begin w_readable = 1'b1; w_rdata = ID_VALUE; end
            default:     ;
        endcase
    end

    // Register side effects: read data capture, scratch, start pulse and
    // the done flag. A start commit beats a same-cycle core_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prdata      <= '0;
            r_scratch     <= '0;
            r_core_start  <= 1'b0;
            r_done_sticky <= 1'b0;
        end else begin
            if (w_rd_commit) r_prdata <= w_rdata;
            if (w_wr_commit && (w_idx == IDX_SCRATCH)) r_scratch <= apb.pwdata;
            r_core_start <= w_start;
            if (w_start)        r_done_sticky <= 1'b0;
            else if (core_done) r_done_sticky <= 1'b1;
        end
    end

    // FIFO pointers, occupancy and sticky overflow. Clear wins over a pop;
    // a push never shares a cycle with clear since both need a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            if (w_push && w_full) r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards them.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) r_mem[r_wr_ptr] <= apb.pwdata;
    end

`ifdef APB_PSLVERR_EN
    logic r_pslverr;
    logic w_err;

    // Error when the address does not support the requested direction;
    // unmapped addresses support neither.
    assign w_err = apb.pwrite ? !w_writable : !w_readable;
    assign apb.pslverr = r_pslverr;

    // Error flag is captured on every commit, reads and writes alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pslverr <= 1'b0;
        end else if (w_commit) begin
            r_pslverr <= w_err;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, apb.paddr[1:0]};
`else
    logic w_unused;
    assign w_unused = &{1'b0, apb.paddr[1:0], w_readable, w_writable};
`endif
endmodule

// File: tb/tb_apb_csr_responder.sv
// ---------------------------------------------------------------------------
// tb_apb_csr_responder
//
// Self-checking bench for apb_csr_responder: a table of register transfers,
// then hand-written sequences for FIFO fill/overflow/drain, start/done and
// reset in the middle of a transfer. Read expectations go into a queue when
// a transfer is driven and are popped when the read data is committed.
// Define APB_PSLVERR_EN to also check pslverr.
// ---------------------------------------------------------------------------
module tb_apb_csr_responder;
    localparam logic [31:0] ID = 32'hA0C2_0016;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coreStart;
    logic        coreBusy;
    logic        coreDone;
    logic [63:0] coreResult;
    logic        wordValid;
    logic [31:0] wordData;
    logic        wordReady;

    int checks = 0;
    int errors = 0;
    int startPulses = 0;

    typedef struct {
        string       name;
        bit          checkData;
        logic [31:0] expData;
        bit          expErr;
    } expect_t;

    typedef struct {
        string       name;
        bit          isWrite;
        logic [7:0]  addr;
        logic [31:0] data;
        int          hold;
        logic [31:0] expData;
        bit          expErr;
    } vec_t;

    expect_t     expQ[$];
    logic [31:0] fifoModel[$];
    vec_t        vecs[14];

    apb_csr_responder_if apb();

    apb_csr_responder #(
        .FIFO_DEPTH (16),
        .ID_VALUE   (ID),
        .RESULT_W   (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .apb         (apb),
        .core_start  (coreStart),
        .core_busy   (coreBusy),
        .core_done   (coreDone),
        .core_result (coreResult),
        .word_valid  (wordValid),
        .word_data   (wordData),
        .word_ready  (wordReady)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Counts cycles in which core_start is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (coreStart) startPulses++;
    end

    // Hard stop if the bench ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison with failure report.
    task automatic checkVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pops the oldest expectation and compares it with the committed data.
    task automatic checkOutput();
        expect_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard actual=empty required=entry");
        end else begin
            e = expQ.pop_front();
            if (e.checkData) checkVal({e.name, " prdata"}, apb.prdata, e.expData);
`ifdef APB_PSLVERR_EN
            checkVal({e.name, " pslverr"}, {31'b0, apb.pslverr}, {31'b0, e.expErr});
`endif
        end
    endtask

    // One APB transfer; psel/penable stay high for 'hold' extra cycles.
    task automatic apbXfer(input bit wr, input logic [7:0] addr,
                           input logic [31:0] data, input int hold);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = addr;
        apb.pwdata  = data;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        @(posedge clk); #1;
        checkOutput();
        repeat (hold) begin @(posedge clk); #1; end
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        expQ.push_back('{name: v.name, checkData: !v.isWrite,
                         expData: v.expData, expErr: v.expErr});
        apbXfer(v.isWrite, v.addr, v.data, v.hold);
    endtask

    task automatic doWrite(input logic [7:0] addr, input logic [31:0] data,
                           input int hold);
        expQ.push_back('{name: "write", checkData: 1'b0, expData: 32'h0, expErr: 1'b0});
        apbXfer(1'b1, addr, data, hold);
    endtask

    task automatic doRead(input string name, input logic [7:0] addr,
                          input logic [31:0] exp);
        expQ.push_back('{name: name, checkData: 1'b1, expData: exp, expErr: 1'b0});
        apbXfer(1'b0, addr, 32'h0, 0);
    endtask

    initial begin
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = 8'h00;
        apb.pwdata  = 32'h0;
        coreBusy    = 1'b0;
        coreDone    = 1'b0;
        coreResult  = 64'h0;
        wordReady   = 1'b0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset prdata", apb.prdata, 32'h0);
        checkVal("reset core_start", {31'b0, coreStart}, 32'h0);
        checkVal("reset word_valid", {31'b0, wordValid}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Register map table: name, write, addr, data, hold, exp data, exp err.
        vecs[0]  = '{"read ID",         1'b0, 8'h18, 32'h0,         0, ID,            1'b0};
        vecs[1]  = '{"read STATUS",     1'b0, 8'h04, 32'h0,         0, 32'h0000_0008, 1'b0};
        vecs[2]  = '{"write SCRATCH",   1'b1, 8'h14, 32'hDEAD_BEEF, 5, 32'h0,         1'b0};
        vecs[3]  = '{"read SCRATCH",    1'b0, 8'h14, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{"read unmapped",   1'b0, 8'h40, 32'h0,         0, 32'h0,         1'b1};
        vecs[5]  = '{"write ID",        1'b1, 8'h18, 32'hFFFF_FFFF, 0, 32'h0,         1'b1};
        vecs[6]  = '{"reread ID",       1'b0, 8'h18, 32'h0,         0, ID,            1'b0};
        vecs[7]  = '{"read CTRL",       1'b0, 8'h00, 32'h0,         0, 32'h0,         1'b1};
        vecs[8]  = '{"read DATA_IN",    1'b0, 8'h08, 32'h0,         0, 32'h0,         1'b1};
        vecs[9]  = '{"write unmapped",  1'b1, 8'h1C, 32'h1234_5678, 0, 32'h0,         1'b1};
        vecs[10] = '{"write STATUS",    1'b1, 8'h04, 32'hFFFF_FFFF, 1, 32'h0,         1'b1};
        vecs[11] = '{"STATUS after wr", 1'b0, 8'h04, 32'h0,         0, 32'h0000_0008, 1'b0};
        vecs[12] = '{"read SCRATCH+2",  1'b0, 8'h16, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{"read RESULT_LO",  1'b0, 8'h0C, 32'h0,         0, 32'h0,         1'b0};
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        // Fill past capacity with varying hold lengths; a re-commit during a
        // hold would show up as a wrong count or an extra word.
        for (int i = 1; i <= 17; i++) begin
            if (fifoModel.size() < 16) fifoModel.push_back(32'(i));
            doWrite(8'h08, 32'(i), i % 3);
        end
        doRead("STATUS full", 8'h04, 32'h0000_1014);

        // Drain: head must follow the model queue, one word per cycle.
        wordReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkVal("pop word_valid", {31'b0, wordValid}, 32'h1);
            if (fifoModel.size() > 0) checkVal("pop word_data", wordData, fifoModel.pop_front());
        end
        @(posedge clk); #1;
        wordReady = 1'b0;
        checkVal("drained word_valid", {31'b0, wordValid}, 32'h0);
        doRead("STATUS drained", 8'h04, 32'h0000_0018);

        // Partial fill then fifo_clear, which also clears overflow.
        for (int i = 0; i < 3; i++) doWrite(8'h08, 32'hA0 + 32'(i), 0);
        doRead("STATUS three", 8'h04, 32'h0000_0310);
        doWrite(8'h00, 32'h2, 0);
        doRead("STATUS cleared", 8'h04, 32'h0000_0008);
        checkVal("cleared word_valid", {31'b0, wordValid}, 32'h0);

        // Start pulse, busy, done and result readback.
        doWrite(8'h00, 32'h1, 0);
        repeat (3) begin @(posedge clk); #1; end
        checkVal("start pulse count", 32'(startPulses), 32'd1);
        coreBusy = 1'b1;
        doRead("STATUS busy", 8'h04, 32'h0000_0009);
        coreResult = 64'h0000_0001_0000_0ABC;
        coreDone   = 1'b1;
        @(posedge clk); #1;
        coreDone = 1'b0;
        coreBusy = 1'b0;
        doRead("STATUS done", 8'h04, 32'h0000_000A);
        doRead("RESULT_LO", 8'h0C, 32'h0000_0ABC);
        doRead("RESULT_HI", 8'h10, 32'h0000_0001);
        doWrite(8'h00, 32'h1, 2);
        repeat (2) begin @(posedge clk); #1; end
        checkVal("second start count", 32'(startPulses), 32'd2);
        doRead("STATUS restart", 8'h04, 32'h0000_0008);

        // Reset during the ACCESS phase of a SCRATCH write, bus left high.
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b1;
        apb.paddr   = 8'h14;
        apb.pwdata  = 32'h1234_5678;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        @(posedge clk); #1;
        doRead("SCRATCH after reset", 8'h14, 32'h0);
        doWrite(8'h14, 32'h55AA_1234, 2);
        doRead("SCRATCH rewrite", 8'h14, 32'h55AA_1234);
        doRead("STATUS after reset", 8'h04, 32'h0000_0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
